// File: rtl/vga_text_console.sv
`default_nettype none
// ============================================================================
// vga_text_console : VGA text console - timing, char buffer, cursor FSM, font pipe
// Revision 1.0
// ============================================================================
module vga_text_console #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          SYNC_POL     = 0,
  parameter int          CHAR_W       = 8,
  parameter int          CHAR_H       = 16,
  parameter logic [11:0] FG_RGB       = 12'hFFF,
  parameter logic [11:0] BG_RGB       = 12'h000,
  parameter int          BLINK_FRAMES = 32,
  localparam int         COLS         = H_ACTIVE / CHAR_W,
  localparam int         ROWS         = V_ACTIVE / CHAR_H,
  localparam int         c_cw         = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int         c_rw         = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int         c_lw         = (CHAR_H > 1) ? $clog2(CHAR_H) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_char_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [8+c_lw-1:0] o_font_addr,
  input  logic [CHAR_W-1:0] i_font_row,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic [3:0]        o_red,
  output logic [3:0]        o_green,
  output logic [3:0]        o_blue,
  output logic [c_cw-1:0]   o_cursor_col,
  output logic [c_rw-1:0]   o_cursor_row,
  output logic              o_frame_start
);
  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_cells   = COLS * ROWS;
  localparam int c_hw      = $clog2(c_h_total);
  localparam int c_vw      = $clog2(c_v_total);
  localparam int c_aw      = (c_cells > 1) ? $clog2(c_cells) : 1;
  localparam int c_bw      = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int c_fw      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0] c_space = 8'h20;
  localparam logic       c_sync_act = (SYNC_POL != 0);

  localparam logic [1:0] c_st_clear_all = 2'd0;
  localparam logic [1:0] c_st_idle      = 2'd1;
  localparam logic [1:0] c_st_clear_row = 2'd2;

  logic [c_hw-1:0] r_h;
  logic [c_vw-1:0] r_v;
  logic            w_h_end, w_v_end, w_active;
  logic [c_fw-1:0] r_blink_cnt;
  logic            r_blink_on;

  assign w_h_end  = (r_h == c_hw'(c_h_total - 1));
  assign w_v_end  = (r_v == c_vw'(c_v_total - 1));
  assign w_active = (r_h < c_hw'(H_ACTIVE)) && (r_v < c_vw'(V_ACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_end) begin
      r_h <= '0;
      r_v <= w_v_end ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Blink phase flips once every BLINK_FRAMES frame wraps; 0 freezes it on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if ((BLINK_FRAMES != 0) && w_h_end && w_v_end) begin
      if (r_blink_cnt == c_fw'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  logic [1:0]      r_state;
  logic [c_aw-1:0] r_clr_cnt;
  logic [c_cw-1:0] r_cur_col;
  logic [c_rw-1:0] r_cur_row;
  logic [c_rw-1:0] w_next_row;
  logic            w_print, w_we;
  logic [c_aw-1:0] w_waddr;
  logic [7:0]      w_wdata;

  assign w_print    = (i_char_data >= 8'h20) && (i_char_data <= 8'h7E);
  assign w_next_row = (r_cur_row == c_rw'(ROWS - 1)) ? '0 : r_cur_row + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_st_clear_all;
      r_clr_cnt <= '0;
      r_cur_col <= '0;
      r_cur_row <= '0;
    end else begin
      case (r_state)
        c_st_clear_all: begin
          if (r_clr_cnt == c_aw'(c_cells - 1)) begin
            r_state   <= c_st_idle;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        c_st_clear_row: begin
          if (r_clr_cnt == c_aw'(COLS - 1)) begin
            r_state   <= c_st_idle;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        c_st_idle: begin
          if (i_data_valid) begin
            if (i_char_data == 8'h0A) begin
              r_cur_col <= '0;
              r_cur_row <= w_next_row;
              r_state   <= c_st_clear_row;
            end else if (i_char_data == 8'h0D) begin
              r_cur_col <= '0;
            end else if (i_char_data == 8'h08) begin
              if (r_cur_col != '0) r_cur_col <= r_cur_col - 1'b1;
            end else if (w_print) begin
              if (r_cur_col == c_cw'(COLS - 1)) begin
                r_cur_col <= '0;
                r_cur_row <= w_next_row;
                r_state   <= c_st_clear_row;
              end else begin
                r_cur_col <= r_cur_col + 1'b1;
              end
            end
          end
        end
        default: r_state <= c_st_clear_all;
      endcase
    end
  end

  // The FSM owns the write port; in CLEAR_ROW the cursor row already names the new row.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = c_space;
    case (r_state)
      c_st_clear_all: begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
      end
      c_st_clear_row: begin
        w_we    = 1'b1;
        w_waddr = c_aw'(int'(r_cur_row) * COLS + int'(r_clr_cnt));
      end
      c_st_idle: begin
        if (i_data_valid && w_print) begin
          w_we    = 1'b1;
          w_waddr = c_aw'(int'(r_cur_row) * COLS + int'(r_cur_col));
          w_wdata = i_char_data;
        end
      end
      default: ;
    endcase
  end

  logic [c_cw-1:0] w_pcol;
  logic [c_rw-1:0] w_prow;
  logic [c_aw-1:0] w_rd_addr;
  logic [7:0]      r_mem [c_cells];
  logic [7:0]      r_char;

  assign w_pcol    = c_cw'(r_h / CHAR_W);
  assign w_prow    = c_rw'(r_v / CHAR_H);
  assign w_rd_addr = w_active ? c_aw'(int'(w_prow) * COLS + int'(w_pcol)) : '0;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_char <= r_mem[w_rd_addr];
  end

  logic [c_lw-1:0] r_s1_line;
  logic [c_bw-1:0] r_s1_bit, r_s2_bit;
  logic            r_s1_cur, r_s1_de, r_s1_hs, r_s1_vs, r_s1_fs;
  logic            r_s2_cur, r_s2_de, r_s2_hs, r_s2_vs, r_s2_fs;
  logic            r_s3_de, r_s3_hs, r_s3_vs, r_s3_fs;
  logic [11:0]     r_rgb;
  logic            w_px;

  assign w_px = i_font_row[c_bw'(CHAR_W - 1) - r_s2_bit] ^ r_s2_cur;

  // Sync/enable flags ride alongside the buffer read and ROM lookup so all arrive together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_line <= '0;
      r_s1_bit  <= '0;
      r_s1_cur  <= 1'b0;
      r_s1_de   <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_vs   <= 1'b0;
      r_s1_fs   <= 1'b0;
      r_s2_bit  <= '0;
      r_s2_cur  <= 1'b0;
      r_s2_de   <= 1'b0;
      r_s2_hs   <= 1'b0;
      r_s2_vs   <= 1'b0;
      r_s2_fs   <= 1'b0;
      r_s3_de   <= 1'b0;
      r_s3_hs   <= 1'b0;
      r_s3_vs   <= 1'b0;
      r_s3_fs   <= 1'b0;
      r_rgb     <= '0;
    end else begin
      r_s1_line <= c_lw'(r_v % CHAR_H);
      r_s1_bit  <= c_bw'(r_h % CHAR_W);
      r_s1_cur  <= w_active && r_blink_on && (w_prow == r_cur_row) && (w_pcol == r_cur_col);
      r_s1_de   <= w_active;
      r_s1_hs   <= (r_h >= c_hw'(H_ACTIVE + H_FP)) && (r_h < c_hw'(H_ACTIVE + H_FP + H_SYNC));
      r_s1_vs   <= (r_v >= c_vw'(V_ACTIVE + V_FP)) && (r_v < c_vw'(V_ACTIVE + V_FP + V_SYNC));
      r_s1_fs   <= (r_h == '0) && (r_v == '0);
      r_s2_bit  <= r_s1_bit;
      r_s2_cur  <= r_s1_cur;
      r_s2_de   <= r_s1_de;
      r_s2_hs   <= r_s1_hs;
      r_s2_vs   <= r_s1_vs;
      r_s2_fs   <= r_s1_fs;
      r_s3_de   <= r_s2_de;
      r_s3_hs   <= r_s2_hs;
      r_s3_vs   <= r_s2_vs;
      r_s3_fs   <= r_s2_fs;
      r_rgb     <= r_s2_de ? (w_px ? FG_RGB : BG_RGB) : 12'h000;
    end
  end

  assign o_font_addr   = {r_char, r_s1_line};
  assign o_data_ready  = (r_state == c_st_idle);
  assign o_hsync       = r_s3_hs ? c_sync_act : ~c_sync_act;
  assign o_vsync       = r_s3_vs ? c_sync_act : ~c_sync_act;
  assign o_de          = r_s3_de;
  assign o_frame_start = r_s3_fs;
  assign o_red         = r_rgb[11:8];
  assign o_green       = r_rgb[7:4];
  assign o_blue        = r_rgb[3:0];
  assign o_cursor_col  = r_cur_col;
  assign o_cursor_row  = r_cur_row;
endmodule
`default_nettype wire

// File: tb/tb_vga_text_console.sv
`default_nettype none
// tb_vga_text_console: directed bench with a console/font model on a reduced timing set.
module tb_vga_text_console;
  localparam int HA = 64, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 48, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int CWD = 8, CHT = 16;
  localparam int COLS = HA / CWD, ROWS = VA / CHT, CELLS = COLS * ROWS;
  localparam int BLINK = 2;
  localparam logic [11:0] FG = 12'h5A3, BG = 12'h0C6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready, hsync, vsync, de, frame_start;
  logic [11:0] font_addr;
  logic [7:0] font_row = 8'h00;
  logic [3:0] red, green, blue;
  logic [2:0] cursor_col;
  logic [1:0] cursor_row;

  vga_text_console #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(0), .CHAR_W(CWD), .CHAR_H(CHT),
    .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .rst(rst),
    .i_char_data(char_data), .i_data_valid(data_valid), .o_data_ready(data_ready),
    .o_font_addr(font_addr), .i_font_row(font_row),
    .o_hsync(hsync), .o_vsync(vsync), .o_de(de),
    .o_red(red), .o_green(green), .o_blue(blue),
    .o_cursor_col(cursor_col), .o_cursor_row(cursor_row),
    .o_frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] font_fn(input logic [7:0] ch, input logic [3:0] ln);
    if (ch == 8'h20) return 8'h00;
    return {ch[3:0] ^ ln, ch[7:4] + ln};
  endfunction

  always @(posedge clk) font_row <= font_fn(font_addr[11:4], font_addr[3:0]);

  int n_cmp = 0, n_err = 0, fs_seen = 0;
  always @(negedge clk) begin
    if (rst) fs_seen = 0;
    else if (frame_start) fs_seen = fs_seen + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] m_mem [CELLS];
  int m_row, m_col;
  logic [11:0] cap_rgb [FRAME+1];
  logic [11:0] cap_fa  [FRAME+1];
  logic        cap_de  [FRAME+1];
  logic        cap_hs  [FRAME+1];
  logic        cap_vs  [FRAME+1];
  logic        cap_fs  [FRAME+1];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h20;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_adv();
    m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    for (int c = 0; c < COLS; c++) m_mem[m_row*COLS + c] = 8'h20;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0A) begin
      m_col = 0;
      model_adv();
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      m_mem[m_row*COLS + m_col] = b;
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_adv();
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " hsync"}, hsync, 1);
    check({tag, " vsync"}, vsync, 1);
    check({tag, " de"}, de, 0);
    check({tag, " rgb"}, {red, green, blue}, 0);
    check({tag, " frame_start"}, frame_start, 0);
    check({tag, " data_ready"}, data_ready, 0);
    check({tag, " cursor"}, {cursor_row, cursor_col}, 0);
  endtask

  // Called at a sample point; returns at the sample just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int k;
    char_data  = b;
    data_valid = 1'b1;
    k = 0;
    while (!data_ready && k < 4*CELLS) begin
      tick();
      k++;
    end
    check("ready_before_accept", data_ready, 1);
    @(posedge clk);
    tick();
    data_valid = 1'b0;
    model_byte(b);
    check("cursor_col", cursor_col, m_col);
    check("cursor_row", cursor_row, m_row);
  endtask

  task automatic count_ready_low(input string tag, input int exp);
    int low;
    low = 0;
    while (!data_ready && low < 4*CELLS) begin
      low++;
      tick();
    end
    check(tag, low, exp);
  endtask

  task automatic check_frame(input string tag);
    int k, n, idx, r, c, e_px, e_hs, e_vs, e_fs, e_fa, n_hs, n_vs, n_de;
    logic [7:0] g;
    logic px, exp_de, exp_hs, exp_vs;
    logic [11:0] exp_rgb;
    k = 0;
    while (!frame_start && k < 2*FRAME) begin
      tick();
      k++;
    end
    check({tag, " frame_found"}, frame_start, 1);
    n = fs_seen - 1;
    for (int i = 0; i <= FRAME; i++) begin
      cap_rgb[i] = {red, green, blue};
      cap_fa[i]  = font_addr;
      cap_de[i]  = de;
      cap_hs[i]  = hsync;
      cap_vs[i]  = vsync;
      cap_fs[i]  = frame_start;
      tick();
    end
    e_px = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_fa = 0; n_hs = 0; n_vs = 0; n_de = 0;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        idx = v*HT + h;
        exp_de  = (h < HA) && (v < VA);
        exp_rgb = 12'h000;
        if (exp_de) begin
          r  = v / CHT;
          c  = h / CWD;
          g  = font_fn(m_mem[r*COLS + c], 4'(v % CHT));
          px = g[7 - (h % CWD)];
          if (r == m_row && c == m_col && ((n / BLINK) % 2 == 0)) px = ~px;
          exp_rgb = px ? FG : BG;
        end
        exp_hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
        exp_vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
        if (cap_rgb[idx] !== exp_rgb || cap_de[idx] !== exp_de) e_px++;
        if (cap_hs[idx] !== exp_hs) e_hs++;
        if (cap_vs[idx] !== exp_vs) e_vs++;
        if (cap_fs[idx] !== (idx == 0)) e_fs++;
        if (v == 0 && cap_hs[idx] == 1'b0) n_hs++;
        if (cap_vs[idx] == 1'b0) n_vs++;
        if (cap_de[idx]) n_de++;
      end
    end
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        if (cap_fa[(rr*CHT + 1)*HT + cc*CWD - 2] !== {m_mem[rr*COLS + cc], 4'd1}) e_fa++;
    check({tag, " pixel_errs"}, e_px, 0);
    check({tag, " hsync_errs"}, e_hs, 0);
    check({tag, " vsync_errs"}, e_vs, 0);
    check({tag, " fs_errs"}, e_fs, 0);
    check({tag, " fs_period"}, cap_fs[FRAME], 1);
    check({tag, " font_addr_errs"}, e_fa, 0);
    check({tag, " hsync_low_per_line"}, n_hs, HS);
    check({tag, " vsync_low_clk"}, n_vs, VS*HT);
    check({tag, " de_count"}, n_de, HA*VA);
  endtask

  initial begin
    int low, first_fs;
    model_reset();
    rst = 1'b1;
    data_valid = 1'b1;
    char_data  = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Power-up clear with a byte held on the input the whole time.
    rst = 1'b0;
    low = 0;
    first_fs = -1;
    for (int k = 0; k < CELLS + 8; k++) begin
      if (!data_ready) low++;
      if (frame_start && first_fs < 0) first_fs = k;
      tick();
    end
    check("clear_all_ready_low", low, CELLS);
    check("first_frame_start_latency", first_fs, 3);
    check("held_ignored_byte_cursor", {cursor_row, cursor_col}, 0);
    data_valid = 1'b0;
    check_frame("blank");

    send_byte(8'h41);
    check_frame("glyph_A");

    send_byte(8'h0D);
    for (int i = 0; i < COLS - 1; i++) send_byte(8'h41);
    send_byte(8'h41);
    count_ready_low("clear_row_ready_low", COLS);
    check_frame("row_wrap");

    send_byte(8'h0D);
    send_byte(8'h08);
    send_byte(8'h42);
    send_byte(8'h08);
    send_byte(8'h7F);
    send_byte(8'h07);
    check_frame("backspace");

    send_byte(8'h0A);
    send_byte(8'h5A);
    send_byte(8'h79);
    send_byte(8'h0A);
    check("wrap_to_origin", {cursor_row, cursor_col}, 0);
    count_ready_low("wrap_clear_ready_low", COLS);
    check_frame("wrap_clear");

    // Reset landing in the middle of a row clear.
    send_byte(8'h0A);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    tick();
    check_reset_outputs("reset_held");
    rst = 1'b0;
    model_reset();
    count_ready_low("reclear_all_ready_low", CELLS);
    check_frame("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
